multdiv_issue_ctrl: RTL and testbench

//  Processor-side initiator for the multicycle mult/div unit. Issues the one-cycle ctrl_MULT/ctrl_DIV

---
 rtl/multdiv_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - X-stage issue/stall/writeback controller for the multicycle mult/div unit
// Issues one start pulse, holds operands, stalls until ready or timeout, then writes back once.
module multdiv_issue_ctrl #(
  parameter int          TIMEOUT     = 40,
  parameter logic [31:0] RSTATUS_MUL = 32'd4,
  parameter logic [31:0] RSTATUS_DIV = 32'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dx_is_mult,
  input  logic        dx_is_div,
  input  logic [4:0]  dx_rd,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic [4:0]    rd_q, rd_d;
  logic          is_div_q, is_div_d;
  logic [31:0]   result_q, result_d;
  logic          exc_q, exc_d;
  logic          terr_q, terr_d;

  logic issue;
  logic done;

  assign issue = (state_q == S_IDLE) && (dx_is_mult || dx_is_div);
  assign done  = (state_q == S_DONE);

  // Simultaneous mul+div resolves to mul.
  assign ctrl_MULT = (state_q == S_IDLE) && dx_is_mult;
  assign ctrl_DIV  = (state_q == S_IDLE) && dx_is_div && !dx_is_mult;

  assign md_operandA = issue ? dx_opA : opa_q;
  assign md_operandB = issue ? dx_opB : opb_q;
  assign stall       = issue || (state_q == S_BUSY);
  assign timeout_err = terr_q;

  assign wb_valid = done;
  assign wb_rd    = !done ? 5'd0 : (exc_q ? 5'd30 : rd_q);
  assign wb_data  = !done ? 32'd0 :
                    exc_q ? (is_div_q ? RSTATUS_DIV : RSTATUS_MUL) : result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    result_d = result_q;
    exc_d    = exc_q;
    terr_d   = terr_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d  = S_BUSY;
          cnt_d    = '0;
          opa_d    = dx_opA;
          opb_d    = dx_opB;
          rd_d     = dx_rd;
          is_div_d = !dx_is_mult;
        end
      end
      S_BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A ready on the first BUSY cycle may belong to a previous operation.
        if ((cnt_q != '0) && md_resultRDY) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          exc_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      terr_q   <= terr_d;
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - randomized self-checking bench for multdiv_issue_ctrl
// Each transaction's timeline is predicted from issue/ready/timeout rules, then compared cycle by cycle.
module tb_multdiv_issue_ctrl;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        dx_is_mult, dx_is_div;
  logic [4:0]  dx_rd;
  logic [31:0] dx_opA, dx_opB;
  logic [31:0] md_result;
  logic        md_exception, md_resultRDY;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] md_operandA, md_operandB;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        timeout_err;

  int  checks = 0;
  int  errors = 0;
  bit  terr_model = 1'b0;

  multdiv_issue_ctrl #(.TIMEOUT(TIMEOUT), .RSTATUS_MUL(32'd4), .RSTATUS_DIV(32'd5)) dut (
    .clk(clk), .reset(reset),
    .dx_is_mult(dx_is_mult), .dx_is_div(dx_is_div), .dx_rd(dx_rd),
    .dx_opA(dx_opA), .dx_opB(dx_opB),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Drives one instruction sitting in X from its issue cycle (k=0) through its writeback cycle.
  // rdy is the cycle offset of the unit's ready pulse (-1 = never); stale adds a ready at k=1.
  task automatic run_txn(input bit m, input bit d, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input int rdy, input bit exc, input logic [31:0] res, input bit stale);
    int          n;
    bit          to;
    bit          ex;
    logic [4:0]  erd;
    logic [31:0] edata;
    // Model: BUSY starts at k=1 and ignores its first cycle; gives up after TIMEOUT BUSY cycles.
    if (rdy >= 2 && rdy <= TIMEOUT) begin n = rdy; to = 1'b0; end
    else begin n = TIMEOUT; to = 1'b1; end
    ex    = to || exc;
    erd   = ex ? 5'd30 : rd;
    edata = ex ? (m ? 32'd4 : 32'd5) : res;
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      dx_is_mult   = m;
      dx_is_div    = d;
      dx_rd        = (k == 0) ? rd : 5'($urandom);
      dx_opA       = (k == 0) ? a : $urandom;
      dx_opB       = (k == 0) ? b : $urandom;
      md_resultRDY = (k == rdy) || (stale && k == 1);
      md_result    = (k == rdy) ? res : $urandom;
      md_exception = (k == rdy) ? exc : 1'($urandom);
      if (to && k == n + 1) terr_model = 1'b1;
      #1;
      checks++;
      if (ctrl_MULT !== (k == 0 && m)) begin
        errors++; $display("FAIL ctrl_MULT k=%0d got %0b exp %0b", k, ctrl_MULT, (k == 0 && m));
      end
      checks++;
      if (ctrl_DIV !== (k == 0 && d && !m)) begin
        errors++; $display("FAIL ctrl_DIV k=%0d got %0b exp %0b", k, ctrl_DIV, (k == 0 && d && !m));
      end
      checks++;
      if (stall !== (k <= n)) begin
        errors++; $display("FAIL stall k=%0d n=%0d got %0b exp %0b", k, n, stall, (k <= n));
      end
      checks++;
      if (wb_valid !== (k == n + 1)) begin
        errors++; $display("FAIL wb_valid k=%0d n=%0d got %0b exp %0b", k, n, wb_valid, (k == n + 1));
      end
      checks++;
      if (wb_rd !== ((k == n + 1) ? erd : 5'd0)) begin
        errors++; $display("FAIL wb_rd k=%0d got %0d exp %0d", k, wb_rd, (k == n + 1) ? erd : 5'd0);
      end
      checks++;
      if (wb_data !== ((k == n + 1) ? edata : 32'd0)) begin
        errors++; $display("FAIL wb_data k=%0d got %0h exp %0h", k, wb_data, (k == n + 1) ? edata : 32'd0);
      end
      checks++;
      if (md_operandA !== a || md_operandB !== b) begin
        errors++; $display("FAIL operands k=%0d got %0h/%0h exp %0h/%0h", k, md_operandA, md_operandB, a, b);
      end
      checks++;
      if (timeout_err !== terr_model) begin
        errors++; $display("FAIL timeout_err k=%0d got %0b exp %0b", k, timeout_err, terr_model);
      end
    end
  endtask

  task automatic idle_cycles(input int cnt, input int rdy_at);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      dx_is_mult   = 1'b0;
      dx_is_div    = 1'b0;
      md_resultRDY = (k == rdy_at);
      md_result    = $urandom;
      #1;
      checks++;
      if (stall !== 1'b0 || wb_valid !== 1'b0 || ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
        errors++;
        $display("FAIL idle k=%0d stall=%0b wb_valid=%0b ctrl=%0b%0b exp all 0", k, stall, wb_valid, ctrl_MULT, ctrl_DIV);
      end
      checks++;
      if (timeout_err !== terr_model) begin
        errors++; $display("FAIL idle_timeout_err k=%0d got %0b exp %0b", k, timeout_err, terr_model);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    dx_is_mult = 0; dx_is_div = 0; dx_rd = 0; dx_opA = 0; dx_opB = 0;
    md_result = 0; md_exception = 0; md_resultRDY = 0;
    #1;
    checks++;
    if ({ctrl_MULT, ctrl_DIV, stall, wb_valid, timeout_err} !== 5'b0 || wb_rd !== 5'd0 ||
        wb_data !== 32'd0 || md_operandA !== 32'd0 || md_operandB !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got ctrl=%0b%0b stall=%0b wb=%0b/%0d/%0h op=%0h/%0h terr=%0b exp all 0",
               ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_rd, wb_data, md_operandA, md_operandB, timeout_err);
    end
    @(negedge clk);
    reset = 1'b0;
    terr_model = 1'b0;
    idle_cycles(2, 0);
  endtask

  task automatic test_mul;
    run_txn(1, 0, 5'd3, 32'd6, 32'd7, 17, 0, 32'd42, 0);
    idle_cycles(1, -1);
  endtask

  task automatic test_div_exception;
    run_txn(0, 1, 5'd9, 32'd100, 32'd0, 12, 1, 32'hdead_beef, 0);
    idle_cycles(1, -1);
  endtask

  task automatic test_stale_ready;
    run_txn(1, 0, 5'd7, 32'h1234, 32'h10, 9, 0, 32'h123400, 1);
    idle_cycles(1, -1);
  endtask

  task automatic test_back_to_back;
    run_txn(1, 0, 5'd4, 32'd11, 32'd13, 5, 0, 32'd143, 0);
    run_txn(0, 1, 5'd6, 32'd99, 32'd3, 2, 0, 32'd33, 1);
    run_txn(1, 0, 5'd8, 32'd2, 32'd2, 3, 1, 32'd4, 0);
    idle_cycles(1, -1);
  endtask

  task automatic test_timeout;
    run_txn(0, 1, 5'd12, 32'd5, 32'd1, TIMEOUT, 0, 32'd5, 0);
    run_txn(1, 0, 5'd13, 32'd77, 32'd88, -1, 0, 32'd0, 0);
    idle_cycles(2, -1);
    run_txn(1, 0, 5'd14, 32'd3, 32'd3, 6, 0, 32'd9, 0);
    idle_cycles(1, -1);
  endtask

  task automatic test_reset_mid_busy;
    run_txn(1, 0, 5'd15, 32'd21, 32'd2, -1, 0, 32'd0, 0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    dx_is_mult = 1; dx_is_div = 0; dx_rd = 5'd15; dx_opA = 32'd21; dx_opB = 32'd2; md_resultRDY = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      md_resultRDY = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b1 || md_operandA !== 32'd21) begin
        errors++; $display("FAIL pre_reset_busy k=%0d stall=%0b opA=%0h exp 1/15", k, stall, md_operandA);
      end
    end
    dx_is_mult = 1'b0;
    #2;
    reset = 1'b1;
    terr_model = 1'b0;
    #1;
    checks++;
    if ({ctrl_MULT, ctrl_DIV, stall, wb_valid, timeout_err} !== 5'b0 || wb_rd !== 5'd0 ||
        wb_data !== 32'd0 || md_operandA !== 32'd0 || md_operandB !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got ctrl=%0b%0b stall=%0b wb=%0b/%0d/%0h op=%0h/%0h terr=%0b exp all 0",
               ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_rd, wb_data, md_operandA, md_operandB, timeout_err);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(12, 8);
  endtask

  task automatic test_both_and_rd0;
    run_txn(1, 1, 5'd20, 32'd8, 32'd9, 4, 0, 32'd72, 0);
    run_txn(1, 0, 5'd0, 32'd5, 32'd5, 3, 0, 32'd25, 0);
    run_txn(1, 1, 5'd21, 32'd8, 32'd9, 4, 1, 32'd72, 0);
    idle_cycles(1, -1);
  endtask

  task automatic test_random;
    for (int t = 0; t < 30; t++) begin
      bit m, d;
      int rdy;
      m   = 1'($urandom);
      d   = m ? 1'($urandom) : 1'b1;
      rdy = ($urandom_range(0, 7) == 0) ? TIMEOUT + 5 : int'($urandom_range(2, 30));
      run_txn(m, d, 5'($urandom), $urandom, $urandom, rdy, 1'($urandom),
              $urandom, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)), -1);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div_exception;
    test_stale_ready;
    test_back_to_back;
    test_timeout;
    test_async_reset;
    test_both_and_rd0;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
